sobel_window_gen: RTL and testbench

Raster-to-window front end for the Sobel edge filter. Accepts one 8-bit grayscale pixel per accepted cycle in row-major order, keeps the two previous image rows in internal line buffers, and presents a registered 3x3 neighbourhood (S00..S22) with a valid strobe. The 3x3 outputs connect directly to the Sobel filter's S00..S22 inputs. Only fully interior windows are emitted; no border padding is produced.

---
 rtl/sobel_window_gen.sv | 133 +++++++++++++
 tb/tb_sobel_window_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// Raster-to-3x3 window generator feeding the Sobel filter; emits only fully interior windows.
// Optional macro SOBEL_WIN_POS_EN adds CX/CY centre-coordinate outputs.
module sobel_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic       CK,
  input  logic       RES,
  input  logic [7:0] PIX_IN,
  input  logic       PIX_VLD,
  input  logic       SOF,
  output logic [7:0] S00,
  output logic [7:0] S01,
  output logic [7:0] S02,
  output logic [7:0] S10,
  output logic [7:0] S11,
  output logic [7:0] S12,
  output logic [7:0] S20,
  output logic [7:0] S21,
  output logic [7:0] S22,
  output logic       WIN_VLD,
  output logic       EOF
`ifdef SOBEL_WIN_POS_EN
  ,
  output logic [$clog2(IMG_W)-1:0] CX,
  output logic [$clog2(IMG_H)-1:0] CY
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic [CW-1:0] col_eff;
  logic [RW-1:0] row_eff;
  logic [CW-1:0] col_next;
  logic [RW-1:0] row_next;

  logic [7:0] lb0 [0:IMG_W-1];
  logic [7:0] lb1 [0:IMG_W-1];

  logic [7:0] win_reg [0:2][0:2];
  logic       win_vld_reg;
  logic       eof_reg;

  // SOF overrides the running position so the qualifying pixel lands at (0,0).
  always_comb begin
    col_eff  = (PIX_VLD && SOF) ? '0 : col_reg;
    row_eff  = (PIX_VLD && SOF) ? '0 : row_reg;
    col_next = col_eff + COL_ONE;
    row_next = row_eff;
    if (col_eff == COL_LAST) begin
      col_next = '0;
      row_next = (row_eff == ROW_LAST) ? '0 : row_eff + ROW_ONE;
    end
  end

  // Line storage is never cleared; rows 0/1 are masked by the row>=2 gate instead.
  always_ff @(posedge CK) begin
    if (PIX_VLD && !RES) begin
      lb0[col_eff] <= lb1[col_eff];
      lb1[col_eff] <= PIX_IN;
    end
  end

  always_ff @(posedge CK) begin
    if (RES) begin
      col_reg     <= '0;
      row_reg     <= '0;
      win_vld_reg <= 1'b0;
      eof_reg     <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_reg[r][c] <= '0;
        end
      end
    end else begin
      win_vld_reg <= PIX_VLD && (col_eff >= COL_TWO) && (row_eff >= ROW_TWO);
      eof_reg     <= PIX_VLD && (col_eff == COL_LAST) && (row_eff == ROW_LAST);
      if (PIX_VLD) begin
        col_reg <= col_next;
        row_reg <= row_next;
        for (int r = 0; r < 3; r++) begin
          win_reg[r][0] <= win_reg[r][1];
          win_reg[r][1] <= win_reg[r][2];
        end
        // Line-buffer taps read the pre-write contents at this column.
        win_reg[0][2] <= lb0[col_eff];
        win_reg[1][2] <= lb1[col_eff];
        win_reg[2][2] <= PIX_IN;
      end
    end
  end

`ifdef SOBEL_WIN_POS_EN
  logic [CW-1:0] cx_reg;
  logic [RW-1:0] cy_reg;

  always_ff @(posedge CK) begin
    if (RES) begin
      cx_reg <= '0;
      cy_reg <= '0;
    end else if (PIX_VLD) begin
      cx_reg <= col_eff - COL_ONE;
      cy_reg <= row_eff - ROW_ONE;
    end
  end

  assign CX = cx_reg;
  assign CY = cy_reg;
`endif

  assign S00     = win_reg[0][0];
  assign S01     = win_reg[0][1];
  assign S02     = win_reg[0][2];
  assign S10     = win_reg[1][0];
  assign S11     = win_reg[1][1];
  assign S12     = win_reg[1][2];
  assign S20     = win_reg[2][0];
  assign S21     = win_reg[2][1];
  assign S22     = win_reg[2][2];
  assign WIN_VLD = win_vld_reg;
  assign EOF     = eof_reg;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 5x4 image; expected windows are built from pixel = base+row*16+col.
module tb_sobel_window_gen;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [7:0] pix_in = 8'h00;
  logic       pix_vld = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] s00, s01, s02, s10, s11, s12, s20, s21, s22;
  logic       win_vld;
  logic       eof;
`ifdef SOBEL_WIN_POS_EN
  logic [2:0] cx;
  logic [1:0] cy;
`endif

  sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .CK(clk), .RES(res), .PIX_IN(pix_in), .PIX_VLD(pix_vld), .SOF(sof),
    .S00(s00), .S01(s01), .S02(s02),
    .S10(s10), .S11(s11), .S12(s12),
    .S20(s20), .S21(s21), .S22(s22),
    .WIN_VLD(win_vld), .EOF(eof)
`ifdef SOBEL_WIN_POS_EN
    , .CX(cx), .CY(cy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0][7:0] s;
    logic            eof;
    logic [2:0]      cx;
    logic [1:0]      cy;
  } exp_t;

  exp_t sb[$];
  exp_t exp_win;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int win_cnt = 0;
  int eof_cnt = 0;
  bit gap_mode = 1'b0;
  bit prev_win = 1'b0;
  bit acc_last = 1'b0;
  logic [8:0][7:0] obs;
  logic [8:0][7:0] snap = '0;

  assign obs = {s22, s21, s20, s12, s11, s10, s02, s01, s00};

  task automatic check(input string tag, input logic [71:0] o, input logic [71:0] e);
    total_cnt++;
    assert (o === e) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  always @(posedge clk) acc_last <= pix_vld || res;

  always @(negedge clk) begin
    if (win_vld) begin
      win_cnt++;
      if (eof) eof_cnt++;
      if (gap_mode) check("no_consec_win", 72'(prev_win), 72'(0));
      if (sb.size() == 0) begin
        check("unexpected_win", 72'(win_vld), 72'(0));
      end else begin
        exp_win = sb.pop_front();
        for (int k = 0; k < 9; k++)
          check($sformatf("S%0d%0d", k / 3, k % 3), 72'(obs[k]), 72'(exp_win.s[k]));
        check("eof", 72'(eof), 72'(exp_win.eof));
`ifdef SOBEL_WIN_POS_EN
        check("cx", 72'(cx), 72'(exp_win.cx));
        check("cy", 72'(cy), 72'(exp_win.cy));
`endif
        $display("win S00=%02h S11=%02h S22=%02h eof=%0d", s00, s11, s22, eof);
      end
    end else if (eof) begin
      check("eof_without_win", 72'(eof), 72'(0));
    end
    if (gap_mode && !acc_last) begin
      check("hold_window", 72'(obs), 72'(snap));
      check("vld_single_pulse", 72'(win_vld), 72'(0));
    end
    prev_win = win_vld;
    snap = obs;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pix(input logic [7:0] base, input int r, input int c, input bit first_sof);
    exp_t e;
    pix_in  = base + 8'(r * 16 + c);
    pix_vld = 1'b1;
    sof     = first_sof;
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.s[i * 3 + j] = base + 8'((r - 2 + i) * 16 + (c - 2 + j));
      e.eof = (r == H - 1) && (c == W - 1);
      e.cx  = 3'(c - 1);
      e.cy  = 2'(r - 1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    pix_vld = 1'b0;
    sof     = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input bit use_sof, input bit gap, input int npix);
    int n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < npix) begin
          send_pix(base, r, c, use_sof && (r == 0) && (c == 0));
          if (gap) idle(1);
        end
        n++;
      end
    end
  endtask

  task automatic end_test(input string name, input int wins, input int eofs);
    idle(3);
    check({name, "_win_count"}, 72'(win_cnt), 72'(wins));
    check({name, "_eof_count"}, 72'(eof_cnt), 72'(eofs));
    check({name, "_sb_empty"}, 72'(sb.size()), 72'(0));
    win_cnt = 0;
    eof_cnt = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_window", 72'(obs), 72'(0));
    check("rst_win_vld", 72'(win_vld), 72'(0));
    check("rst_eof", 72'(eof), 72'(0));
`ifdef SOBEL_WIN_POS_EN
    check("rst_cx", 72'(cx), 72'(0));
    check("rst_cy", 72'(cy), 72'(0));
`endif
    res = 1'b0;
    idle(1);

    // Continuous frame
    send_frame(8'h00, 1'b1, 1'b0, W * H);
    end_test("cont", 6, 1);

    // Same frame with a bubble after every pixel
    gap_mode = 1'b1;
    send_frame(8'h00, 1'b1, 1'b1, W * H);
    idle(2);
    gap_mode = 1'b0;
    end_test("gap", 6, 1);

    // Reset after pixel 0x23, then a new frame without SOF
    send_frame(8'h00, 1'b1, 1'b0, 14);
    res = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_window", 72'(obs), 72'(0));
    check("midrst_win_vld", 72'(win_vld), 72'(0));
    res = 1'b0;
    send_frame(8'h80, 1'b0, 1'b0, W * H);
    end_test("midrst", 8, 1);

    // Two back-to-back frames
    send_frame(8'h00, 1'b1, 1'b0, W * H);
    send_frame(8'h00, 1'b1, 1'b0, W * H);
    end_test("b2b", 12, 2);

    // SOF restarts a partial frame
    send_frame(8'h40, 1'b1, 1'b0, 14);
    send_frame(8'h00, 1'b1, 1'b0, W * H);
    end_test("midsof", 8, 1);

    // Reset coincident with a valid pixel drops that pixel
    send_frame(8'h60, 1'b1, 1'b0, 7);
    res     = 1'b1;
    pix_vld = 1'b1;
    pix_in  = 8'h00;
    sof     = 1'b1;
    @(posedge clk);
    #1;
    res     = 1'b0;
    pix_vld = 1'b0;
    sof     = 1'b0;
    send_frame(8'h00, 1'b0, 1'b0, W * H);
    end_test("rstpix", 6, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
